axi_lite_mem_slave: RTL and testbench
=====================================

# axi_lite_mem_slave
AXI4-Lite slave that acts as the initiator of the single-port synchronous memory interface: it accepts AXI write/read transactions and drives mem_we/mem_addr/mem_wdata, then captures mem_rdata one cycle after the read address is presented. It sits between the AXI interconnect and the on-chip memory, so the memory is host-accessible. It handles one transaction at a time, with alternating priority between reads and writes.
## Interface
- DWIDTH, 32: data width; byte-lane count DWIDTH/8, word-offset bits ALSB = log2(DWIDTH/8).
- MEMSIZE, 10: memory word-address width; AXI address width is MEMSIZE+ALSB.
- clk  in  1  clock, all logic on rising edge.
- xrst  in  1  reset, synchronous, active-low.
- s_awaddr  in  MEMSIZE+ALSB  write byte address.
- s_awvalid / s_awready  in / out  1  AW handshake.
- s_wdata  in  DWIDTH  write data (no WSTRB port: full-word writes only).
- s_wvalid / s_wready  in / out  1  W handshake.
- s_bresp  out  2  write response, constant 2'b00 (OKAY).
- s_bvalid / s_bready  out / in  1  B handshake.
- s_araddr  in  MEMSIZE+ALSB  read byte address.
- s_arvalid / s_arready  in / out  1  AR handshake.
- s_rdata  out  DWIDTH  read data, registered.
- s_rresp  out  2  read response, constant 2'b00.
- s_rvalid / s_rready  out / in  1  R handshake.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  MEMSIZE  memory word address, registered.
- mem_wdata  out  DWIDTH  memory write data, registered.
- mem_rdata  in  DWIDTH  memory read data, valid the cycle after mem_addr is sampled.
## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RWAIT, RRESP. Reset state: IDLE.
- IDLE: a write is pending when s_awvalid&&s_wvalid; a read is pending when s_arvalid. AW alone or W alone is not a pending write.
- Arbitration uses the flag last_wr (reset 0). If both are pending, grant read when last_wr=1, otherwise grant write. If only one is pending, grant it. last_wr updates on every grant.
- Write grant, IDLE->WRITE: register mem_we=1, mem_addr=s_awaddr[MEMSIZE+ALSB-1:ALSB], mem_wdata=s_wdata.
- WRITE: s_awready=s_wready=1 for exactly this cycle; the memory commits the write at the end of the cycle. mem_we clears on the next edge. WRITE->WRESP.
- WRESP: s_bvalid=1 until s_bready=1, then ->IDLE.
- Read grant, IDLE->READ: register mem_addr=s_araddr word address, mem_we=0.
- READ: s_arready=1 for exactly this cycle; the memory samples mem_addr. READ->RWAIT.
- RWAIT: register s_rdata<=mem_rdata. RWAIT->RRESP.
- RRESP: s_rvalid=1 and s_rdata held until s_rready=1, then ->IDLE.
- Address low ALSB bits are ignored (unaligned access maps down to the word). No upper bits exist beyond MEMSIZE+ALSB, so there is no out-of-range case and no SLVERR.
- mem_addr and mem_wdata hold their last value outside grants. mem_we is 1 only in WRITE.
## Timing
- Reset values: all ready/valid outputs 0, mem_we=0, mem_addr=0, mem_wdata=0, s_rdata=0, s_bresp=s_rresp=0, last_wr=0.
- Write: pending at cycle 0 -> AW/W handshake and memory write at cycle 1 -> s_bvalid from cycle 2. Minimum 4 cycles IDLE-to-IDLE with s_bready held 1.
- Read: s_arvalid at cycle 0 -> s_arready at cycle 1 -> capture at cycle 2 -> s_rvalid from cycle 3. Minimum 5 cycles IDLE-to-IDLE.
- A read that directly follows a write to the same address returns the new data, because the write commits before READ.
- Ready signals never assert outside WRITE/READ. Valids are never withdrawn before their handshake (back-pressure holds the state).
- xrst low at any edge: next state IDLE, all outputs at reset values. An in-flight write that has not reached its WRITE edge is dropped. An in-flight response is discarded.
## Test plan
- Write 0xDEADBEEF to byte address 0x10, then read 0x10 -> mem_addr=4 with mem_we pulsed for exactly 1 cycle; bvalid at cycle 2; rdata=0xDEADBEEF, rvalid at cycle 3 of the read, rresp=0.
- Assert awvalid without wvalid for 5 cycles, then assert wvalid -> no awready during the 5 cycles; the write completes normally afterwards.
- Hold awvalid/wvalid/arvalid together from reset -> order is W, R, W, R; the read returns the data from the preceding write.
- Hold rready=0 for 6 cycles in RRESP -> rvalid and rdata stay stable; s_arready and s_awready stay 0 throughout.
- Read byte address 0x13 after writing 0x12345678 to 0x10 -> rdata=0x12345678.
- Drop xrst in WRESP and in RRESP -> next cycle all valids are 0 and state is IDLE; the next write then read works.

Source files
------------

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle for axi_lite_mem_slave: AW, W, B, AR and R channels.
// The master modport is the interconnect side, the slave modport is the
// memory-bridge side.
interface axi_lite_mem_slave_if #(
  parameter int DWIDTH  = 32,
  parameter int MEMSIZE = 10
);
  localparam int ALSB = $clog2(DWIDTH / 8);
  localparam int AW   = MEMSIZE + ALSB;

  logic [AW-1:0]     s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [DWIDTH-1:0] s_wdata;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [AW-1:0]     s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [DWIDTH-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave bridging host accesses onto a single-port synchronous
// memory. One transaction is in flight at a time; when a write and a read
// are both pending in IDLE the grant alternates between them.
module axi_lite_mem_slave #(
  parameter int DWIDTH  = 32,
  parameter int MEMSIZE = 10
) (
  input  logic                 clk,
  input  logic                 xrst,
  axi_lite_mem_slave_if.slave  s_axi,
  output logic                 mem_we,
  output logic [MEMSIZE-1:0]   mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  input  logic [DWIDTH-1:0]    mem_rdata
);
  localparam int ALSB = $clog2(DWIDTH / 8);
  localparam int AW   = MEMSIZE + ALSB;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RWAIT = 3'd4,
    RRESP = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_wr_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              wr_pend;
  logic              rd_pend;
  logic              grant_wr;
  logic              grant_rd;
  logic              awready_c;
  logic              arready_c;
  logic              bvalid_c;
  logic              rvalid_c;
  logic              unused_addr_lsb;

  // Byte-offset bits never reach the memory: unaligned accesses map down to the word.
  assign unused_addr_lsb = ^{s_axi.s_awaddr[ALSB-1:0], s_axi.s_araddr[ALSB-1:0]};

  // Arbitration: a write needs both AW and W; on a tie the side not served last wins.
  always_comb begin
    wr_pend  = s_axi.s_awvalid & s_axi.s_wvalid;
    rd_pend  = s_axi.s_arvalid;
    grant_wr = wr_pend & (~rd_pend | ~last_wr_q);
    grant_rd = rd_pend & (~wr_pend | last_wr_q);
  end

  // Next-state and handshake outputs, decoded from the current state only.
  always_comb begin
    state_d   = state_q;
    awready_c = 1'b0;
    arready_c = 1'b0;
    bvalid_c  = 1'b0;
    rvalid_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d = WRITE;
        end else if (grant_rd) begin
          state_d = READ;
        end
      end
      WRITE: begin
        awready_c = 1'b1;
        state_d   = WRESP;
      end
      WRESP: begin
        bvalid_c = 1'b1;
        if (s_axi.s_bready) begin
          state_d = IDLE;
        end
      end
      READ: begin
        arready_c = 1'b1;
        state_d   = RWAIT;
      end
      RWAIT: begin
        state_d = RRESP;
      end
      RRESP: begin
        rvalid_c = 1'b1;
        if (s_axi.s_rready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and the alternating-priority flag, updated on each grant.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (grant_wr) begin
          last_wr_q <= 1'b1;
        end else if (grant_rd) begin
          last_wr_q <= 1'b0;
        end
      end
    end
  end

  // Memory command registers: loaded on a grant, mem_we high only while in WRITE.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= (state_q == IDLE) && grant_wr;
      if ((state_q == IDLE) && grant_wr) begin
        mem_addr  <= s_axi.s_awaddr[AW-1:ALSB];
        mem_wdata <= s_axi.s_wdata;
      end else if ((state_q == IDLE) && grant_rd) begin
        mem_addr <= s_axi.s_araddr[AW-1:ALSB];
      end
    end
  end

  // Read data capture: memory output is valid during RWAIT and held through RRESP.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      rdata_q <= '0;
    end else if (state_q == RWAIT) begin
      rdata_q <= mem_rdata;
    end
  end

  assign s_axi.s_awready = awready_c;
  assign s_axi.s_wready  = awready_c;
  assign s_axi.s_arready = arready_c;
  assign s_axi.s_bvalid  = bvalid_c;
  assign s_axi.s_rvalid  = rvalid_c;
  assign s_axi.s_bresp   = 2'b00;
  assign s_axi.s_rresp   = 2'b00;
  assign s_axi.s_rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: a driver issues AXI-Lite transactions and
// pushes expected responses; a monitor pops them when B/R handshakes occur.
module tb_axi_lite_mem_slave;
  localparam int DWIDTH  = 32;
  localparam int MEMSIZE = 10;

  logic clk  = 1'b0;
  logic xrst = 1'b0;

  logic               mem_we;
  logic [MEMSIZE-1:0] mem_addr;
  logic [DWIDTH-1:0]  mem_wdata;
  logic [DWIDTH-1:0]  mem_rdata = '0;

  logic [31:0] tb_mem  [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

  int          checks = 0;
  int          errors = 0;
  int          exp_kind[$];
  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];
  int          mon_k;
  logic [31:0] mon_e;

  axi_lite_mem_slave_if #(.DWIDTH(DWIDTH), .MEMSIZE(MEMSIZE)) bus ();

  axi_lite_mem_slave #(.DWIDTH(DWIDTH), .MEMSIZE(MEMSIZE)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Monitor: pops an expected response on every B or R handshake.
  always @(negedge clk) begin
    if (xrst) begin
      check("ready_exclusive", {31'b0, bus.s_awready & bus.s_arready}, 32'd0);
      if (bus.s_bvalid && bus.s_bready) begin
        if (exp_kind.size() == 0 || exp_b.size() == 0) begin
          check("unexpected_b", 32'd1, 32'd0);
        end else begin
          mon_k = exp_kind.pop_front();
          check("order_b", mon_k, 32'd0);
          mon_e = {30'b0, exp_b.pop_front()};
          check("bresp", {30'b0, bus.s_bresp}, mon_e);
        end
      end
      if (bus.s_rvalid && bus.s_rready) begin
        if (exp_kind.size() == 0 || exp_r.size() == 0) begin
          check("unexpected_r", 32'd1, 32'd0);
        end else begin
          mon_k = exp_kind.pop_front();
          check("order_r", mon_k, 32'd1);
          mon_e = exp_r.pop_front();
          check("rdata", bus.s_rdata, mon_e);
          check("rresp", {30'b0, bus.s_rresp}, 32'd0);
        end
      end
    end
  end

  task automatic clear_bus();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_arvalid = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_rready  = 1'b0;
  endtask

  // Called just after a negedge: holds reset for one edge, then checks reset values.
  task automatic do_reset();
    xrst = 1'b0;
    clear_bus();
    exp_kind.delete();
    exp_b.delete();
    exp_r.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, bus.s_awready}, 32'd0);
    check("rst_wready",  {31'b0, bus.s_wready},  32'd0);
    check("rst_arready", {31'b0, bus.s_arready}, 32'd0);
    check("rst_bvalid",  {31'b0, bus.s_bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, bus.s_rvalid},  32'd0);
    check("rst_mem_we",  {31'b0, mem_we},        32'd0);
    check("rst_mem_addr", {22'b0, mem_addr},     32'd0);
    check("rst_mem_wdata", mem_wdata,            32'd0);
    check("rst_rdata",   bus.s_rdata,            32'd0);
    check("rst_resp",    {28'b0, bus.s_bresp, bus.s_rresp}, 32'd0);
    xrst = 1'b1;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input int lead, input int bd, input bit abort);
    int lat;
    @(posedge clk); #1;
    bus.s_awaddr  = addr;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = data;
    bus.s_wvalid  = (lead == 0);
    for (int i = 0; i < lead; i++) begin
      @(negedge clk);
      check("aw_alone_no_ready", {31'b0, bus.s_awready}, 32'd0);
    end
    if (lead > 0) begin
      @(posedge clk); #1;
      bus.s_wvalid = 1'b1;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.s_awready || lat > 20) break;
      lat++;
    end
    check("aw_latency", lat, 32'd1);
    check("w_ready", {31'b0, bus.s_wready}, 32'd1);
    check("wr_mem_we", {31'b0, mem_we}, 32'd1);
    check("wr_mem_addr", {22'b0, mem_addr}, {22'b0, addr[11:2]});
    check("wr_mem_wdata", mem_wdata, data);
    ref_mem[addr[11:2]] = data;
    exp_kind.push_back(0);
    exp_b.push_back(2'b00);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = (bd == 0) && !abort;
    @(negedge clk);
    check("b_latency", {31'b0, bus.s_bvalid}, 32'd1);
    check("mem_we_pulse", {31'b0, mem_we}, 32'd0);
    if (abort) begin
      do_reset();
      return;
    end
    for (int i = 0; i < bd; i++) begin
      @(negedge clk);
      check("b_hold", {31'b0, bus.s_bvalid}, 32'd1);
    end
    if (bd > 0) begin
      @(posedge clk); #1;
      bus.s_bready = 1'b1;
    end
    @(posedge clk); #1;
    bus.s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, input int rd, input bit abort);
    int lat;
    logic [31:0] ev;
    @(posedge clk); #1;
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.s_arready || lat > 20) break;
      lat++;
    end
    check("ar_latency", lat, 32'd1);
    check("rd_mem_we", {31'b0, mem_we}, 32'd0);
    check("rd_mem_addr", {22'b0, mem_addr}, {22'b0, addr[11:2]});
    ev = ref_mem[addr[11:2]];
    exp_kind.push_back(1);
    exp_r.push_back(ev);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = (rd == 0) && !abort;
    @(negedge clk);
    check("rwait_no_valid", {31'b0, bus.s_rvalid}, 32'd0);
    @(negedge clk);
    check("r_latency", {31'b0, bus.s_rvalid}, 32'd1);
    check("r_data_early", bus.s_rdata, ev);
    if (abort) begin
      do_reset();
      return;
    end
    if (rd > 0) begin
      bus.s_awaddr  = 12'(($urandom_range(0, 15) * 4));
      bus.s_wdata   = $urandom;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      bus.s_arvalid = 1'b1;
    end
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      check("r_hold_valid", {31'b0, bus.s_rvalid}, 32'd1);
      check("r_hold_data", bus.s_rdata, ev);
      check("r_hold_ready", {30'b0, bus.s_awready, bus.s_arready}, 32'd0);
    end
    if (rd > 0) begin
      @(posedge clk); #1;
      bus.s_rready = 1'b1;
    end
    @(posedge clk); #1;
    bus.s_rready  = 1'b0;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_arvalid = 1'b0;
  endtask

  // AW, W and AR held together from reset: grants must alternate W, R, W, R.
  task automatic arb_test();
    logic [31:0] d0;
    logic [31:0] d1;
    int grants;
    int cyc;
    d0 = $urandom;
    d1 = ~d0;
    exp_kind.push_back(0); exp_b.push_back(2'b00);
    exp_kind.push_back(1); exp_r.push_back(d0);
    exp_kind.push_back(0); exp_b.push_back(2'b00);
    exp_kind.push_back(1); exp_r.push_back(d1);
    ref_mem[16] = d1;
    bus.s_awaddr  = 12'h040;
    bus.s_araddr  = 12'h042;
    bus.s_wdata   = d0;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_arvalid = 1'b1;
    bus.s_bready  = 1'b1;
    bus.s_rready  = 1'b1;
    grants = 0;
    cyc = 0;
    while (grants < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.s_awready || bus.s_arready) begin
        check("arb_order", {31'b0, bus.s_arready}, 32'(grants % 2));
        grants++;
        @(posedge clk); #1;
        if (grants == 1) bus.s_wdata = d1;
        if (grants == 4) begin
          bus.s_awvalid = 1'b0;
          bus.s_wvalid  = 1'b0;
          bus.s_arvalid = 1'b0;
        end
      end
    end
    check("arb_grants", grants, 32'd4);
    cyc = 0;
    while (exp_kind.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("arb_drain", exp_kind.size(), 32'd0);
    bus.s_bready = 1'b0;
    bus.s_rready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    clear_bus();
    bus.s_awaddr = '0;
    bus.s_araddr = '0;
    bus.s_wdata  = '0;
    repeat (3) @(negedge clk);
    do_reset();

    do_write(12'h010, 32'hDEADBEEF, 0, 0, 1'b0);
    do_read(12'h010, 0, 1'b0);
    do_write(12'h020, 32'hA5A50001, 5, 1, 1'b0);
    do_read(12'h020, 2, 1'b0);
    do_write(12'h010, 32'h12345678, 0, 0, 1'b0);
    do_read(12'h013, 0, 1'b0);
    do_read(12'h010, 6, 1'b0);

    @(negedge clk);
    do_reset();
    arb_test();

    do_write(12'h030, 32'hCAFEF00D, 0, 0, 1'b1);
    do_write(12'h034, 32'h11112222, 0, 0, 1'b0);
    do_read(12'h030, 0, 1'b0);
    do_read(12'h034, 0, 1'b1);
    do_write(12'h038, 32'h33334444, 0, 2, 1'b0);
    do_read(12'h039, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      end else begin
        do_read(a, $urandom_range(0, 3), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("final_drain", exp_kind.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
